// File: rtl/operand_fetch_pkg.sv
// Shared constants and bundle types for the operand fetch stage.
// Build option: OPERAND_FETCH_WB_BYPASS_EN enables same-cycle writeback bypass.
package operand_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int CTRL_W = 16;
  localparam int NREG   = 1 << AW;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [AW-1:0]     rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  function automatic logic is_zero(input logic [AW-1:0] r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/regfile/writeback/execute bundle of the operand fetch stage.
// Build option: OPERAND_FETCH_WB_BYPASS_EN (no effect on this file).
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_rs1;
  logic [AW-1:0]     in_rs2;
  logic [AW-1:0]     in_rd;
  logic              in_rd_we;
  logic [CTRL_W-1:0] in_ctrl;
  logic [AW-1:0]     rf_read_addr1;
  logic [AW-1:0]     rf_read_addr2;
  logic [XLEN-1:0]   rf_data1;
  logic [XLEN-1:0]   rf_data2;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [AW-1:0]     out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2,
    input  in_rd, in_rd_we, in_ctrl,
    input  rf_data1, rf_data2,
    input  wb_valid, wb_addr, wb_data,
    input  out_ready,
    output in_ready, rf_read_addr1, rf_read_addr2,
    output out_valid, out_rs1_val, out_rs2_val,
    output out_rd, out_rd_we, out_ctrl
  );

  modport master (
    output flush, in_valid, in_rs1, in_rs2,
    output in_rd, in_rd_we, in_ctrl,
    output rf_data1, rf_data2,
    output wb_valid, wb_addr, wb_data,
    output out_ready,
    input  in_ready, rf_read_addr1, rf_read_addr2,
    input  out_valid, out_rs1_val, out_rs2_val,
    input  out_rd, out_rd_we, out_ctrl
  );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Busy bit per register for writes issued to execute but not yet written back.
// Build option: OPERAND_FETCH_WB_BYPASS_EN (no effect on this file).
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [AW-1:0]      set_idx,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_idx,
  input  logic [2:0][AW-1:0] q_idx,
  output logic [2:0]         q_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // one-hot set/clear masks; x0 can never become busy
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = NREG'(1) << set_idx;
    if (clr_en) clr_mask = NREG'(1) << clr_idx;
    set_mask[0] = 1'b0;
  end

  // set overrides clear on the same index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

  // raw busy lookup for rs1, rs2, rd
  always_comb begin
    for (int k = 0; k < 3; k++) q_busy[k] = busy[q_idx[k]];
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: hazard check, operand select and output register to execute.
// Build option: OPERAND_FETCH_WB_BYPASS_EN enables same-cycle writeback bypass.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus
);

  of_state_t          state, state_nx;
  id_ex_t             out_q, out_d;
  logic [2:0][AW-1:0] q_idx;
  logic [2:0]         q_busy;
  logic [2:0]         clr_hit;
  logic [2:0]         pend;
  logic [XLEN-1:0]    op1, op2;
  logic               wb_clr, hazard;
  logic               accept, transfer;

  assign bus.rf_read_addr1 = bus.in_rs1;
  assign bus.rf_read_addr2 = bus.in_rs2;
  assign bus.out_valid     = (state == FULL);
  assign bus.out_rs1_val   = out_q.rs1_val;
  assign bus.out_rs2_val   = out_q.rs2_val;
  assign bus.out_rd        = out_q.rd;
  assign bus.out_rd_we     = out_q.rd_we;
  assign bus.out_ctrl      = out_q.ctrl;

  assign q_idx    = {bus.in_rd, bus.in_rs2, bus.in_rs1};
  assign wb_clr   = bus.wb_valid & !is_zero(bus.wb_addr);
  assign transfer = bus.out_valid & bus.out_ready;

  operand_fetch_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (transfer & out_q.rd_we),
    .set_idx (out_q.rd),
    .clr_en  (wb_clr),
    .clr_idx (bus.wb_addr),
    .q_idx   (q_idx),
    .q_busy  (q_busy)
  );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  // writeback this cycle retires the pending write and feeds the operand
  always_comb begin
    for (int k = 0; k < 3; k++)
      clr_hit[k] = wb_clr && (bus.wb_addr == q_idx[k]);
  end
`else
  assign clr_hit = '0;
`endif

  // pending = busy and not retiring now, or held in the output register
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      if (!is_zero(q_idx[k]))
        pend[k] = (q_busy[k] & !clr_hit[k])
                | (bus.out_valid & out_q.rd_we
                   & (out_q.rd == q_idx[k]));
    end
  end

  assign hazard = pend[0] | pend[1] | (bus.in_rd_we & pend[2]);

  assign bus.in_ready = (!bus.out_valid | bus.out_ready)
                      & !hazard & !bus.flush;
  assign accept = bus.in_valid & bus.in_ready;

  // operand select: x0, writeback bypass, then register file
  always_comb begin
    op1 = bus.rf_data1;
    op2 = bus.rf_data2;
    unique case (1'b1)
      is_zero(bus.in_rs1): op1 = '0;
      clr_hit[0]:          op1 = bus.wb_data;
      default:             ;
    endcase
    unique case (1'b1)
      is_zero(bus.in_rs2): op2 = '0;
      clr_hit[1]:          op2 = bus.wb_data;
      default:             ;
    endcase
  end

  // next state of the output register and its payload
  always_comb begin
    state_nx = state;
    out_d    = out_q;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL: begin
        if (bus.flush)                 state_nx = EMPTY;
        else if (transfer && !accept) state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
    if (accept) begin
      out_d.rs1_val = op1;
      out_d.rs2_val = op2;
      out_d.rd      = bus.in_rd;
      out_d.rd_we   = bus.in_rd_we & !is_zero(bus.in_rd);
      out_d.ctrl    = bus.in_ctrl;
    end
  end

  // output register toward execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_q <= '0;
    end else begin
      state <= state_nx;
      out_q <= out_d;
    end
  end

endmodule
